// File: rtl/mvau_weight_loader.sv
// Runtime-writable weight memory for one MVAU PE.
// A weight image arrives over an AXI-stream slave as narrow beats. Each group
// of BEATS beats is packed LSB-first into one SIMD*TW-bit word, and the words
// are written to consecutive RAM addresses. The read side is a plain
// registered port, the same as the preloaded weight memory. The compute
// datapath can use it unchanged once wmem_ready is high.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no valid image (after reset or a framing error); wait for load_start
// LOAD  | accepting beats, packing words and writing them sequentially
// READY | complete image in RAM; load_start begins a fresh reload
module mvau_weight_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int IN_BW        = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    load_start,
    input  logic [IN_BW-1:0]        s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic [SIMD*TW-1:0]      wmem_out,
    output logic                    wmem_ready,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int WORD_W = SIMD * TW;
    localparam int BEATS  = WORD_W / IN_BW;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RAM_AW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(WMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [RAM_AW-1:0]   wr_addr;
    logic [WORD_W-1:0]   word_buf;
    logic [WORD_W-1:0]   word_next;
    logic [WORD_W-1:0]   ram [WMEM_DEPTH];

    logic                beat_xfer;
    logic                word_done;
    logic                image_done;
    logic                early_last;
    logic                ram_we;
    logic                rd_in_range;

    // Partial word with the current beat dropped into its lane slot. The
    // word can be written on the beat that completes it, with no extra cycle.
    always_comb begin
        word_next = word_buf;
        word_next[int'(beat_cnt) * IN_BW +: IN_BW] = s_axis_tdata;
    end

    // tready is high only in LOAD, so a transfer can only happen in LOAD.
    assign beat_xfer  = s_axis_tvalid && s_axis_tready;
    assign word_done  = beat_xfer && (beat_cnt == LAST_BEAT);
    assign image_done = word_done && (wr_addr == LAST_ADDR);

    // tlast anywhere except the final beat of the image is a framing error.
    // The word it belongs to is dropped, even if this beat would complete it.
    assign early_last = beat_xfer && s_axis_tlast && !image_done;
    assign ram_we     = word_done && !early_last;

    // load_done marks the cycle the last word is written. The state
    // changes to READY on the following cycle.
    assign load_done  = image_done;

    // Addresses beyond the populated depth read as zero and do not alias.
    assign rd_in_range = int'(wmem_addr) < WMEM_DEPTH;

    // Load sequencer: state, handshake and status flags, beat/word counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            wmem_ready    <= 1'b0;
            load_err      <= 1'b0;
            beat_cnt      <= '0;
            wr_addr       <= '0;
            word_buf      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state         <= LOAD;
                        s_axis_tready <= 1'b1;
                        load_err      <= 1'b0;
                        beat_cnt      <= '0;
                        wr_addr       <= '0;
                    end
                end

                LOAD: begin
                    if (early_last) begin
                        state         <= IDLE;
                        s_axis_tready <= 1'b0;
                        load_err      <= 1'b1;
                        beat_cnt      <= '0;
                    end else if (beat_xfer) begin
                        word_buf <= word_next;
                        if (word_done) begin
                            beat_cnt <= '0;
                            if (image_done) begin
                                // A missing tlast is flagged, but the image is complete.
                                state         <= READY;
                                s_axis_tready <= 1'b0;
                                wmem_ready    <= 1'b1;
                                if (!s_axis_tlast) begin
                                    load_err <= 1'b1;
                                end
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                READY: begin
                    if (load_start) begin
                        state         <= LOAD;
                        s_axis_tready <= 1'b1;
                        wmem_ready    <= 1'b0;
                        load_err      <= 1'b0;
                        beat_cnt      <= '0;
                        wr_addr       <= '0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    s_axis_tready <= 1'b0;
                    wmem_ready    <= 1'b0;
                end
            endcase
        end
    end

    // Single write port. RAM contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (ram_we) begin
            ram[wr_addr] <= word_next;
        end
    end

    // Registered read port, active in every state. A read to the address
    // being written in the same cycle returns the old contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wmem_out <= '0;
        end else if (rd_in_range) begin
            wmem_out <= ram[wmem_addr[RAM_AW-1:0]];
        end else begin
            wmem_out <= '0;
        end
    end

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Scoreboard bench for mvau_weight_loader (SIMD=2, TW=4, IN_BW=4, depth 4).
// Stimulus pushes expected read data, status snapshots and load_done cycles
// into queues. A single monitor process pops and compares them.
module tb_mvau_weight_loader;

    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int IN_BW = 4;
    localparam int DEPTH = 4;
    localparam int ABW   = 4;
    localparam int WW    = SIMD * TW;
    localparam int BEATS = WW / IN_BW;
    localparam int N     = BEATS * DEPTH;

    logic             aclk;
    logic             aresetn;
    logic             load_start;
    logic [IN_BW-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;
    logic [ABW-1:0]   wmem_addr;
    logic [WW-1:0]    wmem_out;
    logic             wmem_ready;
    logic             load_done;
    logic             load_err;

    mvau_weight_loader #(
        .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW), .IN_BW(IN_BW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .load_start(load_start),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .wmem_addr(wmem_addr), .wmem_out(wmem_out),
        .wmem_ready(wmem_ready), .load_done(load_done), .load_err(load_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        string     name;
        bit        rdy;
        bit        err;
        bit        trdy;
        bit        chk_out;
        logic [WW-1:0] out;
    } stat_t;

    stat_t          st_q[$];
    logic [WW-1:0]  rd_q[$];
    int             done_q[$];

    int   cyc = 0;
    bit   rd_req = 0;
    bit   rd_vld_d = 0;
    bit   st_req = 0;
    bit   tb_done = 0;
    int   checks = 0;
    int   fails = 0;

    // Reference model: the image as a list of beats, plus the memory it implies.
    logic [IN_BW-1:0] bd[N];
    int               gp[N];
    bit               tl[N];
    bit               ls[N];
    logic [WW-1:0]    ref_mem[DEPTH];
    bit               mem_vld[DEPTH];

    always @(posedge aclk) begin
        cyc      <= cyc + 1;
        rd_vld_d <= rd_req;
    end

    function automatic logic [WW-1:0] assemble(input int w);
        logic [WW-1:0] word;
        word = '0;
        for (int k = 0; k < BEATS; k++)
            word = word | (WW'(bd[w*BEATS + k]) << (k*IN_BW));
        return word;
    endfunction

    task automatic check_status(input string nm, input bit rdy, input bit err, input bit trdy,
                                input bit chk_out, input logic [WW-1:0] out);
        stat_t s;
        s.name = nm; s.rdy = rdy; s.err = err; s.trdy = trdy; s.chk_out = chk_out; s.out = out;
        st_q.push_back(s);
        st_req = 1;
        @(posedge aclk); #1;
        st_req = 0;
    endtask

    task automatic set_plain(input logic [IN_BW-1:0] first);
        logic [IN_BW-1:0] v;
        v = first;
        for (int j = 0; j < N; j++) begin
            bd[j] = v; v = v + 1'b1;
            gp[j] = 0; tl[j] = (j == N-1); ls[j] = 0;
        end
    endtask

    task automatic set_random();
        int mode;
        for (int j = 0; j < N; j++) begin
            bd[j] = IN_BW'($urandom_range(0, (1 << IN_BW) - 1));
            gp[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            tl[j] = 0;
            ls[j] = ($urandom_range(0, 7) == 0);
        end
        mode = $urandom_range(0, 5);
        if (mode == 1) tl[$urandom_range(0, N-2)] = 1;
        else if (mode != 0) tl[N-1] = 1;
    endtask

    function automatic bit image_ok();
        for (int j = 0; j < N-1; j++) if (tl[j]) return 0;
        return 1;
    endfunction

    // Drives a load of n beats. Each beat also reads back the word being
    // filled, which must return its previous contents.
    task automatic run_load(input int n, input string nm);
        int  w;
        int  err_at;
        bit  early;
        load_start = 1;
        @(posedge aclk); #1;
        load_start = 0;
        check_status({nm, "_start"}, 0, 0, 1, 0, '0);
        err_at = -1;
        for (int j = 0; j < n; j++) begin
            repeat (gp[j]) begin
                tvalid = 0; tlast = 0; rd_req = 0; load_start = 0;
                @(posedge aclk); #1;
            end
            w = j / BEATS;
            tvalid = 1; tdata = bd[j]; tlast = tl[j]; load_start = ls[j];
            if (mem_vld[w]) begin
                wmem_addr = ABW'(w); rd_req = 1; rd_q.push_back(ref_mem[w]);
            end else begin
                rd_req = 0;
            end
            if (j == N-1) done_q.push_back(cyc);
            early = tl[j] && (j != N-1);
            if (!early && (j % BEATS == BEATS-1)) begin
                ref_mem[w] = assemble(w);
                mem_vld[w] = 1;
            end
            @(posedge aclk); #1;
            if (early) begin
                err_at = j;
                break;
            end
        end
        tvalid = 0; tlast = 0; load_start = 0; rd_req = 0;
        if (err_at >= 0) check_status({nm, "_err"}, 0, 1, 0, 0, '0);
        else if (n == N) check_status({nm, "_end"}, 1, !tl[N-1], 0, 0, '0);
    endtask

    task automatic read_all();
        int off;
        int a;
        off = $urandom_range(0, DEPTH-1);
        for (int i = 0; i < DEPTH; i++) begin
            a = (i + off) % DEPTH;
            wmem_addr = ABW'(a); rd_req = 1; rd_q.push_back(ref_mem[a]);
            @(posedge aclk); #1;
        end
        rd_req = 0;
    endtask

    // Stimulus
    initial begin
        aresetn = 0; load_start = 0; tdata = '0; tvalid = 0; tlast = 0; wmem_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; mem_vld[i] = 0; end
        repeat (3) @(posedge aclk); #1;
        check_status("reset", 0, 0, 0, 1, '0);
        aresetn = 1;
        @(posedge aclk); #1;
        check_status("idle", 0, 0, 0, 1, '0);

        set_plain(4'h1);            run_load(N, "s1"); read_all();
        set_plain(4'hA);            run_load(N, "s5"); read_all();
        set_plain(4'h1); gp[3] = 3; run_load(N, "s2"); read_all();
        set_plain(4'h1); tl[4] = 1; run_load(N, "s3");
        set_plain(4'h1);            run_load(N, "s3ok"); read_all();
        set_plain(4'h5); tl[N-1] = 0; run_load(N, "s4"); read_all();

        set_plain(4'h3); run_load(4, "s6");
        @(posedge aclk); #1;
        aresetn = 0;
        check_status("s6_rst", 0, 0, 0, 1, '0);
        aresetn = 1;
        load_start = 1;
        @(posedge aclk); #1;
        load_start = 0;
        repeat (4) @(posedge aclk); #1;
        check_status("s6_noload", 0, 0, 1, 0, '0);

        for (int r = 0; r < 10; r++) begin
            set_random();
            run_load(N, "rnd");
            if (image_ok()) read_all();
        end

        repeat (3) @(posedge aclk); #1;
        tb_done = 1;
    end

    // Monitor and scoreboard
    initial begin : monitor
        stat_t         s;
        logic [WW-1:0] e;
        int            c;
        while (!tb_done) begin
            @(negedge aclk);
            if (rd_vld_d) begin
                checks++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_underflow: got %02h, no expected read queued", wmem_out);
                end else begin
                    e = rd_q.pop_front();
                    if (wmem_out !== e) begin
                        fails++;
                        $display("FAIL rd_data: got %02h expected %02h at cycle %0d", wmem_out, e, cyc);
                    end
                end
            end
            if (st_req && st_q.size() != 0) begin
                s = st_q.pop_front();
                checks += 3;
                if (wmem_ready !== s.rdy) begin
                    fails++;
                    $display("FAIL %s wmem_ready: got %b expected %b", s.name, wmem_ready, s.rdy);
                end
                if (load_err !== s.err) begin
                    fails++;
                    $display("FAIL %s load_err: got %b expected %b", s.name, load_err, s.err);
                end
                if (tready !== s.trdy) begin
                    fails++;
                    $display("FAIL %s tready: got %b expected %b", s.name, tready, s.trdy);
                end
                if (s.chk_out) begin
                    checks += 2;
                    if (wmem_out !== s.out) begin
                        fails++;
                        $display("FAIL %s wmem_out: got %02h expected %02h", s.name, wmem_out, s.out);
                    end
                    if (load_done !== 1'b0) begin
                        fails++;
                        $display("FAIL %s load_done: got %b expected 0", s.name, load_done);
                    end
                end
            end
            if (load_done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL load_done_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    c = done_q.pop_front();
                    if (c != cyc) begin
                        fails++;
                        $display("FAIL load_done_cycle: got cycle %0d expected %0d", cyc, c);
                    end
                end
            end
        end
        checks++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL load_done_missing: %0d pulses outstanding, expected 0", done_q.size());
        end
        checks++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: reads %0d status %0d left, expected 0", rd_q.size(), st_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "time limit");
    end

endmodule
